// File: rtl/multi_lane_reg_loader.sv
// Multi-channel, LANES-bit-per-beat register loader with whole-frame commit.
// Optional parity beat per frame: define LOADER_PARITY_EN.
module multi_lane_reg_loader #(
  parameter int LANES   = 4,
  parameter int REGSIZE = 128,
  parameter int NCH     = 2,
  parameter int SELW    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       din,
  input  logic [SELW-1:0]        sel,
  input  logic                   load,
  input  logic                   clr,
  input  logic                   clr_all,
  output logic [NCH*REGSIZE-1:0] regs_out,
  output logic [NCH-1:0]         pending,
  output logic [NCH-1:0]         done,
  output logic                   sel_err,
  output logic                   par_err
);

  localparam int BEATS = REGSIZE / LANES;
`ifdef LOADER_PARITY_EN
  localparam int CNTW  = $clog2(BEATS + 2);
`else
  localparam int CNTW  = $clog2(BEATS + 1);
`endif
  localparam logic [CNTW-1:0] LAST_DATA = CNTW'(BEATS - 1);
  localparam logic [SELW:0]   NCH_W     = NCH[SELW:0];

  generate
    if (((REGSIZE % LANES) != 0) || ((1 << SELW) < NCH)) begin : g_bad_cfg
      $error("multi_lane_reg_loader: REGSIZE must be a multiple of LANES and 2**SELW >= NCH");
    end
  endgenerate

  logic [NCH-1:0][REGSIZE-1:0] r_shadow;
  logic [NCH-1:0][REGSIZE-1:0] r_regs;
  logic [NCH-1:0][CNTW-1:0]    r_cnt;
  logic [NCH-1:0]              r_done;
  logic                        r_sel_err;
`ifdef LOADER_PARITY_EN
  logic [NCH-1:0][LANES-1:0]   r_par;
  logic                        r_par_err;
`endif

  logic                        w_sel_ok;
  logic [NCH-1:0]              w_clr_ch;
  logic [NCH-1:0]              w_load_ch;
  logic [NCH-1:0][REGSIZE-1:0] w_shifted;

  assign w_sel_ok = ({1'b0, sel} < NCH_W);

  // Decode the shared strobes into per-channel actions; clr masks a same-cycle load.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_clr_ch  = '0;
    w_load_ch = '0;
    w_shifted = '0;
    for (int k = 0; k < NCH; k++) begin
      w_clr_ch[k]  = clr && w_sel_ok && (sel == SELW'(k));
      w_load_ch[k] = load && !clr && w_sel_ok && (sel == SELW'(k));
      // The cast keeps the low REGSIZE bits: oldest beat drops out of the top.
      w_shifted[k] = REGSIZE'({r_shadow[k], din});
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-channel arrays are plain flops, not RAM, so resetting them is both legal and required here.
      r_shadow  <= '0;
      r_regs    <= '0;
      r_cnt     <= '0;
      r_done    <= '0;
      r_sel_err <= 1'b0;
`ifdef LOADER_PARITY_EN
      r_par     <= '0;
      r_par_err <= 1'b0;
`endif
    end else begin
      r_done    <= '0;
      r_sel_err <= 1'b0;
`ifdef LOADER_PARITY_EN
      r_par_err <= 1'b0;
`endif
      if (clr_all) begin
        r_shadow <= '0;
        r_regs   <= '0;
        r_cnt    <= '0;
`ifdef LOADER_PARITY_EN
        r_par    <= '0;
`endif
      end else begin
        r_sel_err <= (load || clr) && !w_sel_ok;
        for (int k = 0; k < NCH; k++) begin
          if (w_clr_ch[k]) begin
            r_shadow[k] <= '0;
            r_cnt[k]    <= '0;
`ifdef LOADER_PARITY_EN
            r_par[k]    <= '0;
`endif
          end else if (w_load_ch[k]) begin
`ifdef LOADER_PARITY_EN
            if (r_cnt[k] == CNTW'(BEATS)) begin
              // Parity beat: never shifted in, only compared against the fold.
              r_cnt[k] <= '0;
              r_par[k] <= '0;
              if (din == r_par[k]) begin
                r_regs[k] <= r_shadow[k];
                r_done[k] <= 1'b1;
              end else begin
                r_par_err <= 1'b1;
              end
            end else begin
              r_shadow[k] <= w_shifted[k];
              r_par[k]    <= r_par[k] ^ din;
              r_cnt[k]    <= r_cnt[k] + 1'b1;
            end
`else
            r_shadow[k] <= w_shifted[k];
            if (r_cnt[k] == LAST_DATA) begin
              r_regs[k] <= w_shifted[k];
              r_cnt[k]  <= '0;
              r_done[k] <= 1'b1;
            end else begin
              r_cnt[k]  <= r_cnt[k] + 1'b1;
            end
`endif
          end
        end
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < NCH; k++) begin
      pending[k] = (r_cnt[k] != '0);
    end
  end

  assign regs_out = r_regs;
  assign done     = r_done;
  assign sel_err  = r_sel_err;
`ifdef LOADER_PARITY_EN
  assign par_err  = r_par_err;
`else
  assign par_err  = 1'b0;
`endif

endmodule
